// File: rtl/alsu_tx_pkg.sv
// Shared types and constants for the ALSU result serial transmitter.
// Optional feature macro: ALSU_TX_PARITY_EN (adds an even parity bit to every frame).
package alsu_tx_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_e;

   localparam int         DATA_BITS = 7;
   localparam logic [7:0] OVF_MAX   = 8'hFF;

   // Even parity over one captured entry (err flag plus 6-bit result).
   function automatic logic evenParity(input logic [DATA_BITS-1:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/alsu_result_fifo.sv
// Small circular FIFO holding captured ALSU entries until the serialiser takes them.
// The head word is always presented; the consumer latches it on the same edge it pops.
// Optional feature macro: ALSU_TX_PARITY_EN (not used in this file).
module alsu_result_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 7
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic [WIDTH-1:0]         i_data,
   output logic [WIDTH-1:0]         o_headData,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wrPtr;
   logic [PTR_W-1:0] r_rdPtr;
   logic [PTR_W:0]   r_count;

   // Storage array; contents need no reset because the count gates every read.
   always_ff @(posedge clk) begin
      if (i_push) begin
         r_mem[r_wrPtr] <= i_data;
      end
   end

   // Pointers wrap naturally at DEPTH; the extra count bit separates full from empty.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (i_push) begin
            r_wrPtr <= r_wrPtr + 1'b1;
         end
         if (i_pop) begin
            r_rdPtr <= r_rdPtr + 1'b1;
         end
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_headData = r_mem[r_rdPtr];
   assign o_full     = (r_count == (PTR_W+1)'(DEPTH));
   assign o_empty    = (r_count == '0);
   assign o_count    = r_count;

endmodule

// File: rtl/alsu_result_tx.sv
// Captures qualified ALSU results into a FIFO and drains them as framed LSB-first
// serial words on a single idle-high line. Overflowing captures are dropped and counted.
// Optional feature macro: ALSU_TX_PARITY_EN (even parity bit after err, 10-bit frames);
// without it frames are start + 7 data + stop.
module alsu_result_tx
   import alsu_tx_pkg::*;
#(
   parameter int DEPTH    = 8,
   parameter int BAUD_DIV = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_in_valid,
   input  logic [5:0]               i_in_out,
   input  logic [15:0]              i_in_leds,
   input  logic                     i_tx_en,
   output logic                     o_tx,
   output logic                     o_tx_busy,
   output logic [$clog2(DEPTH):0]   o_fifo_count,
   output logic [7:0]               o_ovf_cnt
);

   localparam int BAUD_W = $clog2(BAUD_DIV + 1);
   localparam int BIT_W  = $clog2(DATA_BITS);

   tx_state_e            r_state;
   tx_state_e            w_nextState;
   logic [DATA_BITS-1:0] r_shift;
   logic [DATA_BITS-1:0] w_nextShift;
   logic [BIT_W-1:0]     r_bitCnt;
   logic [BIT_W-1:0]     w_nextBitCnt;
   logic [BAUD_W-1:0]    r_baudCnt;
   logic [BAUD_W-1:0]    w_nextBaudCnt;
   logic                 r_tx;
   logic                 w_nextTx;
   logic                 r_busy;
   logic [7:0]           r_ovfCnt;
`ifdef ALSU_TX_PARITY_EN
   logic                 r_parity;
   logic                 w_nextParity;
`endif

   logic                 w_push;
   logic                 w_pop;
   logic                 w_full;
   logic                 w_empty;
   logic                 w_startOk;
   logic                 w_baudEnd;
   logic [DATA_BITS-1:0] w_entry;
   logic [DATA_BITS-1:0] w_headData;

   assign w_entry   = {|i_in_leds, i_in_out};
   assign w_startOk = i_tx_en && !w_empty;
   assign w_baudEnd = (r_baudCnt == BAUD_W'(BAUD_DIV - 1));
   assign w_push    = i_in_valid && (!w_full || w_pop);

   alsu_result_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (DATA_BITS)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .i_push     (w_push),
      .i_pop      (w_pop),
      .i_data     (w_entry),
      .o_headData (w_headData),
      .o_full     (w_full),
      .o_empty    (w_empty),
      .o_count    (o_fifo_count)
   );

   // Next-state and next-line decode; the line value is computed one edge ahead so tx is registered.
   always_comb begin
      w_nextState   = r_state;
      w_nextShift   = r_shift;
      w_nextBitCnt  = r_bitCnt;
      w_nextBaudCnt = w_baudEnd ? '0 : r_baudCnt + 1'b1;
      w_nextTx      = 1'b1;
      w_pop         = 1'b0;
`ifdef ALSU_TX_PARITY_EN
      w_nextParity  = r_parity;
`endif
      case (r_state)
         IDLE: begin
            w_nextBaudCnt = '0;
            w_pop         = w_startOk;
         end
         START: begin
            w_nextTx = 1'b0;
            if (w_baudEnd) begin
               w_nextState = DATA;
               w_nextTx    = r_shift[0];
            end
         end
         DATA: begin
            w_nextTx = r_shift[0];
            if (w_baudEnd) begin
               if (r_bitCnt == BIT_W'(DATA_BITS - 1)) begin
`ifdef ALSU_TX_PARITY_EN
                  w_nextState = PARITY;
                  w_nextTx    = r_parity;
`else
                  w_nextState = STOP;
                  w_nextTx    = 1'b1;
`endif
               end else begin
                  w_nextBitCnt = r_bitCnt + 1'b1;
                  w_nextShift  = r_shift >> 1;
                  w_nextTx     = r_shift[1];
               end
            end
         end
`ifdef ALSU_TX_PARITY_EN
         PARITY: begin
            w_nextTx = r_parity;
            if (w_baudEnd) begin
               w_nextState = STOP;
               w_nextTx    = 1'b1;
            end
         end
`endif
         STOP: begin
            w_nextTx = 1'b1;
            if (w_baudEnd) begin
               w_nextState = IDLE;
               w_pop       = w_startOk;
            end
         end
         default: begin
            w_nextState   = IDLE;
            w_nextBaudCnt = '0;
         end
      endcase
      if (w_pop) begin
         w_nextState   = START;
         w_nextShift   = w_headData;
         w_nextBitCnt  = '0;
         w_nextBaudCnt = '0;
         w_nextTx      = 1'b0;
`ifdef ALSU_TX_PARITY_EN
         w_nextParity  = evenParity(w_headData);
`endif
      end
   end

   // Frame state, counters, shift register and registered line/busy outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_shift   <= '0;
         r_bitCnt  <= '0;
         r_baudCnt <= '0;
         r_tx      <= 1'b1;
         r_busy    <= 1'b0;
`ifdef ALSU_TX_PARITY_EN
         r_parity  <= 1'b0;
`endif
      end else begin
         r_state   <= w_nextState;
         r_shift   <= w_nextShift;
         r_bitCnt  <= w_nextBitCnt;
         r_baudCnt <= w_nextBaudCnt;
         r_tx      <= w_nextTx;
         r_busy    <= (w_nextState != IDLE);
`ifdef ALSU_TX_PARITY_EN
         r_parity  <= w_nextParity;
`endif
      end
   end

   // Saturating count of captures that found the FIFO full with no pop to make room.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ovfCnt <= '0;
      end else if (i_in_valid && !w_push && (r_ovfCnt != OVF_MAX)) begin
         r_ovfCnt <= r_ovfCnt + 1'b1;
      end
   end

   assign o_tx      = r_tx;
   assign o_tx_busy = r_busy;
   assign o_ovf_cnt = r_ovfCnt;

endmodule

// File: tb/tb_alsu_result_tx.sv
// Directed self-checking bench for alsu_result_tx (DEPTH=8, BAUD_DIV=4).
// Expected frames follow ALSU_TX_PARITY_EN when it is defined for the build.
module tb_alsu_result_tx;

   localparam int DEPTH    = 8;
   localparam int BAUD_DIV = 4;
`ifdef ALSU_TX_PARITY_EN
   localparam int FRAME_BITS = 10;
`else
   localparam int FRAME_BITS = 9;
`endif

   logic        clk;
   logic        rst;
   logic        inValid;
   logic [5:0]  inOut;
   logic [15:0] inLeds;
   logic        txEn;
   logic        tx;
   logic        txBusy;
   logic [3:0]  fifoCount;
   logic [7:0]  ovfCnt;

   int total = 0;
   int bad   = 0;

   alsu_result_tx #(
      .DEPTH    (DEPTH),
      .BAUD_DIV (BAUD_DIV)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .i_in_valid   (inValid),
      .i_in_out     (inOut),
      .i_in_leds    (inLeds),
      .i_tx_en      (txEn),
      .o_tx         (tx),
      .o_tx_busy    (txBusy),
      .o_fifo_count (fifoCount),
      .o_ovf_cnt    (ovfCnt)
   );

   // Free-running clock; DUT acts on rising edges, bench works on falling edges.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drives one capture for a single rising edge, returning at the following falling edge.
   task automatic applyStimulus(input logic [5:0] outVal, input logic [15:0] ledsVal);
      inValid = 1'b1;
      inOut   = outVal;
      inLeds  = ledsVal;
      @(negedge clk);
      inValid = 1'b0;
   endtask

   // Expected frame, LSB first: start, result bits, err, [parity], stop.
   function automatic logic [9:0] makeFrame(input logic [5:0] outVal, input logic errVal);
`ifdef ALSU_TX_PARITY_EN
      return {1'b1, ^{errVal, outVal}, errVal, outVal, 1'b0};
`else
      return {1'b0, 1'b1, errVal, outVal, 1'b0};
`endif
   endfunction

   // Called at the falling edge just before the pop edge; checks every cycle of one frame.
   task automatic checkFrame(input string tag, input logic [9:0] bits);
      for (int i = 0; i < FRAME_BITS * BAUD_DIV; i++) begin
         @(negedge clk);
         checkOutput($sformatf("%s_tx_c%0d", tag, i), {31'b0, tx}, {31'b0, bits[i / BAUD_DIV]});
         checkOutput($sformatf("%s_busy_c%0d", tag, i), {31'b0, txBusy}, 32'd1);
      end
   endtask

   initial begin
      logic [9:0] frameA;
      logic [9:0] frameB;
      logic [9:0] frameC;
      logic [5:0] vals [10];

      rst     = 1'b1;
      txEn    = 1'b1;
      inValid = 1'b0;
      inOut   = '0;
      inLeds  = '0;

      // Reset values, then 50 idle cycles with tx_en high and an empty FIFO.
      repeat (2) @(negedge clk);
      checkOutput("rst_tx", {31'b0, tx}, 32'd1);
      checkOutput("rst_busy", {31'b0, txBusy}, 32'd0);
      checkOutput("rst_count", {28'b0, fifoCount}, 32'd0);
      checkOutput("rst_ovf", {24'b0, ovfCnt}, 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         checkOutput("idle_tx", {31'b0, tx}, 32'd1);
         checkOutput("idle_busy", {31'b0, txBusy}, 32'd0);
         checkOutput("idle_count", {28'b0, fifoCount}, 32'd0);
         checkOutput("idle_ovf", {24'b0, ovfCnt}, 32'd0);
      end

      // Single capture 6'b101101, no error: 0,1,0,1,1,0,1,0,[0],1.
      $display("[TB] single capture");
`ifdef ALSU_TX_PARITY_EN
      frameA = 10'b1001011010;
`else
      frameA = 10'b0101011010;
`endif
      applyStimulus(6'b101101, 16'h0000);
      checkOutput("single_count_push", {28'b0, fifoCount}, 32'd1);
      checkOutput("single_tx_pre", {31'b0, tx}, 32'd1);
      checkOutput("single_busy_pre", {31'b0, txBusy}, 32'd0);
      checkFrame("single", frameA);
      @(negedge clk);
      checkOutput("single_busy_post", {31'b0, txBusy}, 32'd0);
      checkOutput("single_tx_post", {31'b0, tx}, 32'd1);
      checkOutput("single_count_post", {28'b0, fifoCount}, 32'd0);

      // Error flag from leds: data 0 x6 then err=1, [parity 1], stop.
      $display("[TB] error flag capture");
`ifdef ALSU_TX_PARITY_EN
      frameB = 10'b1110000000;
`else
      frameB = 10'b0110000000;
`endif
      applyStimulus(6'h00, 16'h0001);
      checkFrame("errflag", frameB);
      @(negedge clk);
      checkOutput("errflag_busy_post", {31'b0, txBusy}, 32'd0);

      // Ten captures with tx_en low: eight stored, two dropped; then eight frames back-to-back.
      $display("[TB] overflow and back-to-back drain");
      txEn = 1'b0;
      for (int k = 0; k < 10; k++) begin
         vals[k] = 6'(k * 5 + 1);
         applyStimulus(vals[k], (k % 2 == 1) ? 16'h0100 : 16'h0000);
         inValid = 1'b1;
      end
      inValid = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("ovf_count_full", {28'b0, fifoCount}, 32'd8);
      checkOutput("ovf_cnt_2", {24'b0, ovfCnt}, 32'd2);
      checkOutput("ovf_busy_held", {31'b0, txBusy}, 32'd0);
      checkOutput("ovf_tx_held", {31'b0, tx}, 32'd1);
      txEn = 1'b1;
      for (int k = 0; k < 8; k++) begin
         checkFrame($sformatf("drain%0d", k), makeFrame(vals[k], (k % 2 == 1)));
      end
      @(negedge clk);
      checkOutput("drain_busy_post", {31'b0, txBusy}, 32'd0);
      checkOutput("drain_count_post", {28'b0, fifoCount}, 32'd0);
      checkOutput("drain_ovf_post", {24'b0, ovfCnt}, 32'd2);

      // Refill to full, then capture on the pop edge: count stays 8, no drop.
      $display("[TB] push and pop on a full FIFO");
      txEn = 1'b0;
      for (int k = 0; k < 8; k++) begin
         applyStimulus(6'(8'h30 + k), 16'h0000);
      end
      @(negedge clk);
      checkOutput("full_count", {28'b0, fifoCount}, 32'd8);
      txEn    = 1'b1;
      inValid = 1'b1;
      inOut   = 6'h2A;
      inLeds  = 16'h0000;
      @(negedge clk);
      checkOutput("pushpop_count", {28'b0, fifoCount}, 32'd8);
      checkOutput("pushpop_ovf", {24'b0, ovfCnt}, 32'd2);
      checkOutput("pushpop_busy", {31'b0, txBusy}, 32'd1);
      checkOutput("pushpop_tx", {31'b0, tx}, 32'd0);

      // 300 drops with the FIFO full and no new frames: counter saturates at 255.
      txEn  = 1'b0;
      inOut = 6'h15;
      repeat (100) @(negedge clk);
      checkOutput("drop100_ovf", {24'b0, ovfCnt}, 32'd102);
      repeat (200) @(negedge clk);
      inValid = 1'b0;
      checkOutput("drop300_ovf", {24'b0, ovfCnt}, 32'd255);
      checkOutput("drop300_count", {28'b0, fifoCount}, 32'd8);
      checkOutput("drop300_busy", {31'b0, txBusy}, 32'd0);
      @(negedge clk);
      checkOutput("drop_hold_ovf", {24'b0, ovfCnt}, 32'd255);

      // Reset during data bit 3 of entry 0x31 (bit 3 is 0): line must rise at once.
      $display("[TB] reset mid-frame");
      txEn = 1'b1;
      repeat (18) @(negedge clk);
      checkOutput("midframe_tx_bit3", {31'b0, tx}, 32'd0);
      checkOutput("midframe_busy", {31'b0, txBusy}, 32'd1);
      rst = 1'b1;
      #1;
      checkOutput("midrst_tx", {31'b0, tx}, 32'd1);
      checkOutput("midrst_busy", {31'b0, txBusy}, 32'd0);
      checkOutput("midrst_count", {28'b0, fifoCount}, 32'd0);
      checkOutput("midrst_ovf", {24'b0, ovfCnt}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checkOutput("postrst_tx", {31'b0, tx}, 32'd1);
         checkOutput("postrst_busy", {31'b0, txBusy}, 32'd0);
      end

      // Fresh capture after reset: all ones with err set.
`ifdef ALSU_TX_PARITY_EN
      frameC = 10'b1111111110;
`else
      frameC = 10'b0111111110;
`endif
      applyStimulus(6'h3F, 16'h8000);
      checkOutput("final_count_push", {28'b0, fifoCount}, 32'd1);
      checkFrame("final", frameC);
      @(negedge clk);
      checkOutput("final_busy_post", {31'b0, txBusy}, 32'd0);
      checkOutput("final_count_post", {28'b0, fifoCount}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
